// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the dmem round-robin arbiter.
// SC result codes follow RISC-V: zero means the store-conditional succeeded.
package dmem_arb_pkg;

  localparam int NCORES_MAX = 8;

  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

  // Index width for n requesters, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter_rr_grant.sv
// Combinational round-robin grant: searches from rr_ptr+1 upward (mod NCORES)
// and returns the first requester as a one-hot vector and a binary index.
module rr_grant
  import dmem_arb_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int IDXW   = clog2_min1(NCORES)
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [IDXW-1:0]   rr_ptr_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IDXW-1:0]   gnt_idx_o
);

  logic found;

  // Outer loop walks priority order; inner loop keeps every select constant.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 1; i <= NCORES; i++) begin
      for (int k = 0; k < NCORES; k++) begin
        if (!found && req_i[k] && (k == ((int'(rr_ptr_i) + i) % NCORES))) begin
          found     = 1'b1;
          gnt_o[k]  = 1'b1;
          gnt_idx_o = IDXW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one 1-cycle BRAM port among NCORES harts, with LR/SC
// reservations. Define DMEM_ARB_STATS_EN to add conflict / SC-fail counters.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORES     = 4,
  parameter int DMEM_ADDRW = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  input  logic [4*NCORES-1:0]          wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic [NCORES-1:0]            stall_packed_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]                  stats_conflict_o,
  output logic [31:0]                  stats_sc_fail_o,
`endif
  output logic                         mem_en_o,
  output logic [3:0]                   mem_wstrb_o,
  output logic [DMEM_ADDRW-1:0]        mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int IDXW = clog2_min1(NCORES);

  logic [NCORES-1:0]     req, gnt;
  logic [IDXW-1:0]       gnt_idx;
  logic                  any_req;
  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]       rsp_idx_q;
  logic                  rsp_rd_q, rsp_sc_q, sc_fail_q;
  logic [NCORES-1:0]     resv_valid_q, resv_valid_d;
  logic [DMEM_ADDRW-1:0] resv_addr_q [NCORES];
  logic [DMEM_ADDRW-1:0] resv_addr_d [NCORES];

  logic [DMEM_ADDRW-1:0] g_addr, g_resv_addr;
  logic [31:0]           g_wdata;
  logic [3:0]            g_wstrb;
  logic                  g_rd, g_wr, g_lr, g_sc, g_resv_valid;
  logic                  sc_ok, wr_done;

  // Holding off requests during reset keeps stall and mem_en low while rst_ni is low.
  assign req     = (re_packed_i | we_packed_i) & {NCORES{rst_ni}};
  assign any_req = |req;

  rr_grant #(
    .NCORES (NCORES),
    .IDXW   (IDXW)
  ) u_rr_grant (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign stall_packed_o = req & ~gnt;

  always_comb begin
    g_addr      = '0;
    g_wdata     = '0;
    g_wstrb     = '0;
    g_resv_addr = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (gnt[k]) begin
        g_addr      = addr_packed_i[k*DMEM_ADDRW +: DMEM_ADDRW];
        g_wdata     = wdata_packed_i[k*32 +: 32];
        g_wstrb     = wstrb_packed_i[k*4 +: 4];
        g_resv_addr = resv_addr_q[k];
      end
    end
  end

  // A hart raising both re and we is treated as a write.
  assign g_wr         = |(gnt & we_packed_i);
  assign g_rd         = |(gnt & re_packed_i) & ~g_wr;
  assign g_lr         = g_rd & |(gnt & is_lr_packed_i);
  assign g_sc         = g_wr & |(gnt & is_sc_packed_i);
  assign g_resv_valid = |(gnt & resv_valid_q);
  assign sc_ok        = g_resv_valid && (g_resv_addr == g_addr);
  assign wr_done      = g_wr & (~g_sc | sc_ok);

  assign mem_en_o    = any_req;
  assign mem_addr_o  = g_addr;
  assign mem_wdata_o = g_wdata;
  assign mem_wstrb_o = wr_done ? g_wstrb : 4'b0000;

  always_comb begin
    rr_ptr_d     = any_req ? gnt_idx : rr_ptr_q;
    resv_valid_d = resv_valid_q;
    for (int m = 0; m < NCORES; m++) begin
      resv_addr_d[m] = resv_addr_q[m];
      if (wr_done && (resv_addr_q[m] == g_addr)) resv_valid_d[m] = 1'b0;
      if (gnt[m] && g_lr) begin
        resv_valid_d[m] = 1'b1;
        resv_addr_d[m]  = g_addr;
      end
      if (gnt[m] && g_sc) resv_valid_d[m] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      rsp_idx_q    <= '0;
      rsp_rd_q     <= 1'b0;
      rsp_sc_q     <= 1'b0;
      sc_fail_q    <= 1'b0;
      resv_valid_q <= '0;
      for (int m = 0; m < NCORES; m++) resv_addr_q[m] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_idx_q    <= gnt_idx;
      rsp_rd_q     <= g_rd;
      rsp_sc_q     <= g_sc;
      sc_fail_q    <= g_sc & ~sc_ok;
      resv_valid_q <= resv_valid_d;
      for (int m = 0; m < NCORES; m++) resv_addr_q[m] <= resv_addr_d[m];
    end
  end

  // Only the lane granted last cycle carries data; write responses stay zero.
  always_comb begin
    rdata_packed_o = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (rsp_idx_q == IDXW'(k)) begin
        if (rsp_rd_q)      rdata_packed_o[k*32 +: 32] = mem_rdata_i;
        else if (rsp_sc_q) rdata_packed_o[k*32 +: 32] = sc_fail_q ? SC_FAIL : SC_SUCCESS;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stats_conflict_q, stats_sc_fail_q;
  logic        multi_req;

  assign multi_req = |(req & (req - NCORES'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_conflict_q <= '0;
      stats_sc_fail_q  <= '0;
    end else begin
      if (multi_req && (stats_conflict_q != '1)) stats_conflict_q <= stats_conflict_q + 32'd1;
      if (g_sc && !sc_ok && (stats_sc_fail_q != '1)) stats_sc_fail_q <= stats_sc_fail_q + 32'd1;
    end
  end

  assign stats_conflict_o = stats_conflict_q;
  assign stats_sc_fail_o  = stats_sc_fail_q;
`endif

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Shares one single-port, 1-cycle-latency data-memory BRAM port among NCORES CPU data-bus requesters.
- Grants one request per cycle using round-robin priority, and stalls every other requester.
- Tracks a per-hart LR/SC reservation and returns SC success/fail codes.
- Sits between the per-core dmem decode (re/we/addr/wdata/wstrb/is_lr/is_sc, packed) and the dmem BRAM. Stall outputs are ORed into each core's stall_i.

Parameters:
- NCORES, 4, number of requesting harts (1..8).
- DMEM_ADDRW, 12, word-address width of the data memory (4096 words = 16 KiB).
- IDXW, $clog2(NCORES) (min 1), width of the grant index; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- re_packed_i  in  NCORES  per-hart read request
- we_packed_i  in  NCORES  per-hart write request
- addr_packed_i  in  DMEM_ADDRW*NCORES  per-hart word address
- wdata_packed_i  in  32*NCORES  per-hart write data
- wstrb_packed_i  in  4*NCORES  per-hart byte strobes
- is_lr_packed_i  in  NCORES  read is LR.W
- is_sc_packed_i  in  NCORES  write is SC.W
- rdata_packed_o  out  32*NCORES  per-hart read data / SC result
- stall_packed_o  out  NCORES  per-hart stall (combinational)
- mem_en_o  out  1  BRAM enable
- mem_wstrb_o  out  4  BRAM byte write enables (0 = read)
- mem_addr_o  out  DMEM_ADDRW  BRAM word address
- mem_wdata_o  out  32  BRAM write data
- mem_rdata_i  in  32  BRAM read data, valid 1 cycle after enable

Behaviour:
- **Requests and stalls**
  - req[k] = re[k] | we[k]. A requester holds its request unchanged while stalled.
  - stall[k] = req[k] & ~gnt[k], combinational in the same cycle. Never assert stall for a non-requester.
- **Arbitration**
  - rr_ptr register, reset 0. It holds the index of the last granted hart.
  - Priority order is rr_ptr+1, rr_ptr+2, … mod NCORES. Exactly one grant when any req is set.
  - On grant, rr_ptr <= granted index. With no request, rr_ptr holds.
- **Memory port (all driven from the granted hart, combinational)**
  - mem_en_o = |req.
  - mem_addr_o = granted hart's address.
  - mem_wdata_o = granted hart's write data.
  - mem_wstrb_o = granted wstrb for a plain write, 0 for a read, and gated by the SC outcome for SC.
  - With no request: all memory outputs are 0.
- **Reservations**
  - Per hart: resv_valid[k] and resv_addr[k]; all resv_valid reset to 0.
  - Granted LR: resv_valid[g] <= 1, resv_addr[g] <= addr; the read proceeds normally.
  - Granted SC: succeeds iff resv_valid[g] && resv_addr[g]==addr.
    - Success: write performed and resv_valid[g] cleared.
    - Fail: mem_wstrb_o = 0 and resv_valid[g] cleared.
  - Any performed write (plain or successful SC) to address A clears resv_valid[m] for every m with resv_addr[m]==A, the writer included.
  - The single port serialises all events, so no same-cycle conflicts exist.
- **Read return (latency 1)**
  - Registered rsp_idx, rsp_rd and rsp_sc record the granted hart, whether the access was a read, and whether it was an SC.
  - Next cycle, rdata[rsp_idx] = mem_rdata_i for a read, or {31'b0, sc_fail_q} for an SC.
  - All other lanes are 0. Plain-write responses are 0.
- **Reset**
  - rst_ni low: all registers clear asynchronously; stall_packed_o = 0 and mem_en_o = 0 while reset is held.
  - An in-flight read's response is dropped.
  - NCORES==1: always grant, never stall.

Optional Feature:
- DMEM_ARB_STATS_EN.
- Defined:
  - Adds output stats_conflict_o [31:0]: saturating count of cycles with more than one req set.
  - Adds output stats_sc_fail_o [31:0]: saturating count of failed SCs.
  - Both clear on reset.
- Undefined: these ports and their counters do not exist.

Decomposition:
- dmem_arb_pkg holds:
  - SC_SUCCESS = 32'd0 and SC_FAIL = 32'd1.
  - A clog2 helper for IDXW.
  - An NCORES upper-bound constant (8).
- Sub-module rr_grant, purely combinational: inputs req[NCORES] and rr_ptr; outputs a one-hot gnt and the binary gnt_idx. Parameterised by NCORES; unit-testable alone.

Test Plan:
- Cores 0–3 read addresses 0x10, 0x20, 0x30, 0x40 continuously from reset with rr_ptr=0:
  - Grants follow 1,2,3,0.
  - Each core stalls 3 of every 4 cycles.
  - rdata for a core appears exactly 1 cycle after its grant, with values preloaded in the BRAM model.
- Core 1 LR 0x100, then SC 0x100 with 0xDEADBEEF, no interference:
  - SC returns 0.
  - BRAM word 0x100 = 0xDEADBEEF.
- Core 1 LR 0x100, core 2 stores 0x5 to 0x100, then core 1 SC 0x100:
  - SC returns 1.
  - mem_wstrb_o = 0 on the SC grant cycle.
  - Word stays 0x5.
- Core 0 SC 0x80 with no prior LR:
  - Returns 1, no write.
  - A second LR/SC pair to 0x80 then succeeds.
- Core 3 write with wstrb=4'b0010 to 0x7 while core 0 reads 0x7 in the same cycle with rr_ptr=2:
  - Core 3 is granted first; core 0 stalls 1 cycle.
  - Core 0 then reads the merged byte.
- rst_ni pulsed low while a read is granted:
  - Outputs go to 0 immediately; rr_ptr = 0; reservations clear.
  - No stale rdata appears after release.
  - With DMEM_ARB_STATS_EN defined, both counters read 0.
